mem_port_arbiter: RTL

- Shares the single unified memory port of the multicycle core between two requesters: m0 = core (fetch/load/store) and m1 = loader/debug master.
- Accepts one transaction at a time, drives the memory for one cycle and waits a fixed read latency.
- Returns completion and read data to the winning requester.
- Round-robin arbitration by default.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_pick.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-master memory port arbiter.
//   arb_state_t : arbiter FSM states
//   master_id_t : requester identity (M_CORE = core, M_AUX = loader/debug)
//   LAT_W       : width of the read-latency wait counter (MEM_LAT <= 15)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    M_CORE = 1'b0,
    M_AUX  = 1'b1
  } master_id_t;

  localparam int LAT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational winner select between the core (req0) and the loader (req1).
//   req0, req1 : raw request lines
//   last_grant : master that completed the most recent transaction
//   valid      : at least one request present
//   winner     : selected master (meaningful only when valid)
// Build option: define ARB_FIXED_PRIORITY_EN for fixed priority (core always
// wins a tie, last_grant ignored); default is round-robin.
// -----------------------------------------------------------------------------
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  master_id_t last_grant,
  output logic       valid,
  output master_id_t winner
);

  assign valid = req0 | req1;

`ifdef ARB_FIXED_PRIORITY_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    winner = M_CORE;
    if (!req0 && req1) begin
      winner = M_AUX;
    end
  end
`else
  // On a tie the master that did not win last time goes first.
  always_comb begin
    winner = M_CORE;
    if (req0 && req1) begin
      if (last_grant == M_CORE) begin
        winner = M_AUX;
      end
    end else if (req1) begin
      winner = M_AUX;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between the core (m0) and a loader/debug master (m1).
// One transaction at a time: grant in IDLE, one ACCESS cycle on the memory,
// MEM_LAT cycles of WAIT, then a one-cycle RESP with mN_done.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   mN_req/we/adr/wdata             : requester inputs (N = 0,1)
//   mN_gnt                          : combinational accept, IDLE only
//   mN_done, mN_rdata               : completion pulse and held read data
//   mem_en/we/adr/wdata, mem_rdata  : memory port
//   busy                            : high whenever the FSM is not in IDLE
//   dbg_state_o                     : current FSM state
// Parameters: AW, DW, MEM_LAT (1..15, fits LAT_W).
// Build option: ARB_FIXED_PRIORITY_EN selects fixed priority in arb_pick.
//
// Handshake: a requester raises mN_req with its fields and holds them until it
// sees mN_gnt; in the gnt cycle the fields are latched, so afterwards they may
// change freely. Dropping req before gnt withdraws it. req still high in the
// cycle after gnt is a new request, served at the next IDLE.
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_done,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_done,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output arb_state_t    dbg_state_o
);

  arb_state_t        state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  master_id_t        win_q, win_d;
  master_id_t        last_q, last_d;
  logic              we_q, we_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW-1:0]     rdata0_q, rdata0_d;
  logic [DW-1:0]     rdata1_q, rdata1_d;

  logic              pick_valid;
  master_id_t        pick_winner;

  arb_pick u_pick (
    .req0       (m0_req),
    .req1       (m1_req),
    .last_grant (last_q),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    last_d    = last_q;
    we_d      = we_q;
    adr_d     = adr_q;
    wdata_d   = wdata_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_done   = 1'b0;
    m1_done   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;

    case (state_q)
      IDLE: begin
        // Grant is suppressed while reset is asserted so outputs stay 0.
        if (pick_valid && !reset) begin
          win_d   = pick_winner;
          state_d = ACCESS;
          if (pick_winner == M_AUX) begin
            m1_gnt  = 1'b1;
            we_d    = m1_we;
            adr_d   = m1_adr;
            wdata_d = m1_wdata;
          end else begin
            m0_gnt  = 1'b1;
            we_d    = m0_we;
            adr_d   = m0_adr;
            wdata_d = m0_wdata;
          end
        end
      end
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_adr   = adr_q;
        mem_wdata = wdata_q;
        cnt_d     = LAT_W'(MEM_LAT);
        state_d   = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - LAT_W'(1);
        // Count of 1 marks the cycle where mem_rdata is valid.
        if (cnt_q == LAT_W'(1)) begin
          state_d = RESP;
          if (!we_q) begin
            if (win_q == M_AUX) begin
              rdata1_d = mem_rdata;
            end else begin
              rdata0_d = mem_rdata;
            end
          end
        end
      end
      RESP: begin
        if (win_q == M_AUX) begin
          m1_done = 1'b1;
        end else begin
          m0_done = 1'b1;
        end
        last_d  = win_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      win_q    <= M_CORE;
      last_q   <= M_AUX;
      we_q     <= 1'b0;
      adr_q    <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      last_q   <= last_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign m0_rdata    = rdata0_q;
  assign m1_rdata    = rdata1_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule
